// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding and default parameters.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package i2c_pkg;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
  localparam int         DEF_NREGS    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA pins and flags SCL edges plus START/STOP conditions.
// Latency: 3 clk from pin change to event pulse (2 sync flops + registered detect).
// Backpressure: none; events are single-cycle pulses that must be consumed when seen.
module i2c_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] are the metastability pair, [2] is the one-cycle-older copy for edges
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  // Shift pins through the synchronizer chain; idle bus level (1) during reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_in};
      sda_sh <= {sda_sh[1:0], sda_in};
    end
  end

  // Register edge and START/STOP pulses; START/STOP need SCL high on both samples
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_rise  <=  scl_sh[1] & ~scl_sh[2];
      scl_fall  <= ~scl_sh[1] &  scl_sh[2];
      start_det <=  scl_sh[1] &  scl_sh[2] & ~sda_sh[1] &  sda_sh[2];
      stop_det  <=  scl_sh[1] &  scl_sh[2] &  sda_sh[1] & ~sda_sh[2];
    end
  end

  // Delayed SDA lines up with the registered event pulses
  assign sda = sda_sh[2];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS 8-bit registers with an auto-incrementing pointer.
// Latency: 3 clk pin-to-event; sda_out updates 1 clk after a detected SCL fall.
// Backpressure: none; never stretches SCL, wr_valid strobes cannot be stalled.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         NREGS    = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_out,
  output logic                     busy,
  output logic                     wr_valid,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  input  logic [$clog2(NREGS)-1:0] host_addr,
  output logic [7:0]               host_rdata
);

  localparam int PW = $clog2(NREGS);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .resetn    (resetn),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [PW-1:0] ptr;
  logic          rw;
  logic          first_byte;   // next written byte is the register pointer
  logic          mack;         // controller's ACK/NACK bit after a read byte
  logic [7:0]    regs [NREGS];

  assign host_rdata = regs[host_addr];

  // Bus protocol FSM; START/STOP override every state, data bits move on SCL edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      ptr        <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      mack       <= 1'b1;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        // ptr is kept so a pointer write can be followed by a repeated-START read
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_out <= 1'b1;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_out <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == DEV_ADDR) begin
                state      <= ADDR_ACK;
                sda_out    <= 1'b0;
                busy       <= 1'b1;
                rw         <= shreg[0];
                first_byte <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state   <= RD_BYTE;
                shreg   <= regs[ptr];
                sda_out <= regs[ptr][7];
              end else begin
                state   <= WR_BYTE;
                sda_out <= 1'b1;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state   <= WR_ACK;
              sda_out <= 1'b0;
              bit_cnt <= 4'd0;
              if (first_byte) begin
                first_byte <= 1'b0;
                ptr        <= shreg[PW-1:0];
              end else begin
                regs[ptr] <= shreg;
                wr_valid  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= shreg;
                ptr       <= ptr + PW'(1);
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state   <= WR_BYTE;
              sda_out <= 1'b1;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RD_ACK;
                sda_out <= 1'b1;
                bit_cnt <= 4'd0;
                ptr     <= ptr + PW'(1);
              end else begin
                sda_out <= shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              mack <= sda;
            end else if (scl_fall) begin
              if (!mack) begin
                state   <= RD_BYTE;
                shreg   <= regs[ptr];
                sda_out <= regs[ptr][7];
              end else begin
                state   <= IGNORE;
                sda_out <= 1'b1;
              end
            end
          end
          default: begin
            // IDLE and IGNORE wait for the next START with SDA released
            sda_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit I2C target address matched after START.
REQ-002 SHALL have parameter NREGS, default 16, the number of 8-bit registers (power of two); pointer width is log2(NREGS).
REQ-003 SHALL have port clk  input  1  system clock, at least 16x the SCL rate.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port scl_in  input  1  raw SCL pin level, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  raw SDA pin level, asynchronous to clk.
REQ-007 SHALL have port sda_out  output  1  1 = release SDA, 0 = drive low; feeds the open_drain_pin buffer.
REQ-008 SHALL have port busy  output  1  high from an address-matched START until STOP or the next START.
REQ-009 SHALL have port wr_valid  output  1  one-cycle strobe per register written by the bus.
REQ-010 SHALL have port wr_addr  output  log2(NREGS)  register index for wr_valid.
REQ-011 SHALL have port wr_data  output  8  data for wr_valid.
REQ-012 SHALL have port host_addr  input  log2(NREGS)  fabric read index.
REQ-013 SHALL have port host_rdata  output  8  combinational reg[host_addr].

Function
REQ-014 SHALL pass scl_in and sda_in through 2-flop synchronizers plus one delay flop; all events are detected from synchronized values, with a 3-cycle pin-to-event latency.
REQ-015 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both SHALL be honoured in every state.
REQ-016 SHALL sample data bits MSB-first on the SCL rising edge and change sda_out only on the cycle after an SCL falling edge; no clock stretching.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-018 SHALL enter ADDR on any START, including a repeated START from any state, and SHALL enter IDLE on STOP.
REQ-019 SHALL, after 8 ADDR bits, go to ADDR_ACK and drive sda_out=0 for the 9th clock if bits[7:1]==DEV_ADDR; otherwise it SHALL go to IGNORE with sda_out=1.
REQ-020 SHALL, after ADDR_ACK, go to WR_BYTE when R/W=0, or to RD_BYTE when R/W=1, loading the shifter with reg[ptr].
REQ-021 SHALL treat the first WR_BYTE after an address as the pointer: ptr = byte modulo NREGS, and no wr_valid.
REQ-022 SHALL treat each later WR_BYTE as data: write reg[ptr], pulse wr_valid one cycle with wr_addr=ptr, then increment ptr.
REQ-023 SHALL ACK every written byte (WR_ACK, sda_out=0 for the 9th clock).
REQ-024 SHALL, in RD_BYTE, drive the shifter MSB-first and increment ptr after bit 8.
REQ-025 SHALL, in RD_ACK, release SDA and sample the controller's bit: ACK (0) reloads reg[ptr] and returns to RD_BYTE; NACK (1) goes to IGNORE.
REQ-026 SHALL wrap the pointer from NREGS-1 to 0 on increment.
REQ-027 SHALL preserve ptr across repeated START, to allow the write-pointer-then-read sequence.
REQ-028 SHALL abort on a STOP or START mid-byte: discard the partial byte, issue no wr_valid, and release SDA.
REQ-029 SHALL hold sda_out=1 in IDLE, ADDR, IGNORE, and all controller-driven bit times.

Reset
REQ-030 SHALL, while resetn is low, force state=IDLE, ptr=0, all registers=8'h00, sda_out=1, busy=0, wr_valid=0, wr_addr=0, wr_data=0, and synchronizer flops=1.
REQ-031 SHALL, on reset release mid-transaction, ignore bus activity until the next START.

Structure
REQ-032 SHALL place the state enum, the default DEV_ADDR, and the default NREGS in shared package i2c_pkg.
REQ-033 SHALL use one sub-module, i2c_line_sync (synchronizers, edge and START/STOP detection), reusable by hdmi_i2c_ctrl.
REQ-034 SHALL target 150-300 lines of RTL in total.

Verification
REQ-035 SHALL cover: write 0x50/W, ptr 0x03, data 0xA5 0x5A -> two ACKs, wr_valid at (3,0xA5) then (4,0x5A), host_rdata[4]=0x5A.
REQ-036 SHALL cover: after REQ-035, write 0x50/W ptr 0x03, repeated START, 0x50/R, read 2 bytes ACK then NACK -> 0xA5, 0x5A, SDA released after NACK.
REQ-037 SHALL cover: address 0x51/W -> no ACK (SDA high on 9th clock), no wr_valid, busy=0.
REQ-038 SHALL cover: ptr 0x0F, write 0x11 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap).
REQ-039 SHALL cover: STOP after 4 bits of a data byte -> no wr_valid, state IDLE, next transaction acknowledged normally.
REQ-040 SHALL cover: resetn asserted during RD_BYTE while driving a 0 -> sda_out=1 immediately, all registers read 0x00.
